// File: rtl/mac_pkg.sv
// Shared constants, defaults and side-band type for the mac_pipe block.
package mac_pkg;

   localparam int WIDTH_DEF     = 18;
   localparam int STAGES_DEF    = 1;
   localparam int ACC_WIDTH_DEF = 48;

   localparam logic [1:0] MODE_MUL  = 2'd0;
   localparam logic [1:0] MODE_MAC  = 2'd1;
   localparam logic [1:0] MODE_MSUB = 2'd2;

   // Per-sample control that rides alongside the operands/product.
   typedef struct packed {
      logic [1:0] mode;
      logic       clr;
   } mac_sb_t;

   // Signed overflow of r = x + y, given the three sign bits.
   function automatic logic add_ovf(input logic sx, input logic sy, input logic sr);
      return (sx == sy) && (sr != sx);
   endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Input register, operand extension, multiplier and STAGES product registers,
// with the valid bit and per-sample side-band carried in lock-step.
module mac_mult_pipe
   import mac_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int STAGES    = STAGES_DEF,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_a,
   input  logic                 signed_b,
   input  logic [1:0]           mode,
   input  logic                 clr_acc,
   output logic                 prod_valid,
   output logic [ACC_WIDTH-1:0] prod,
   output mac_sb_t              prod_sb
);

   logic signed [WIDTH:0] a_ext_d, a_ext_q;
   logic signed [WIDTH:0] b_ext_d, b_ext_q;
   logic                  in_vld_d, in_vld_q;
   mac_sb_t               in_sb_d, in_sb_q;

   // Capture operands extended by one bit according to their signed flag;
   // data only loads on a real sample, the valid bit follows in_valid.
   always_comb begin
      in_vld_d = in_valid;
      a_ext_d  = a_ext_q;
      b_ext_d  = b_ext_q;
      in_sb_d  = in_sb_q;
      if (in_valid) begin
         a_ext_d      = {signed_a & a[WIDTH-1], a};
         b_ext_d      = {signed_b & b[WIDTH-1], b};
         in_sb_d.mode = mode;
         in_sb_d.clr  = clr_acc;
      end
   end

   // Input register stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_vld_q <= 1'b0;
         a_ext_q  <= '0;
         b_ext_q  <= '0;
         in_sb_q  <= '0;
      end else if (en) begin
         in_vld_q <= in_vld_d;
         a_ext_q  <= a_ext_d;
         b_ext_q  <= b_ext_d;
         in_sb_q  <= in_sb_d;
      end
   end

   // Multiply at accumulator width. The exact product of two (WIDTH+1)-bit
   // signed values always fits in 2*WIDTH bits once the sign rules are
   // applied, so the low ACC_WIDTH bits of a signed multiply equal the
   // sign-extended (or, for two unsigned operands, zero-extended) product.
   logic signed [ACC_WIDTH-1:0] a_wide, b_wide, prod0;
   always_comb begin
      a_wide = ACC_WIDTH'(a_ext_q);
      b_wide = ACC_WIDTH'(b_ext_q);
      prod0  = a_wide * b_wide;
   end

   if (STAGES == 0) begin : g_bypass
      assign prod_valid = in_vld_q;
      assign prod       = prod0;
      assign prod_sb    = in_sb_q;
   end else begin : g_stages
      logic    [STAGES-1:0]                vld_pipe_d, vld_pipe_q;
      logic    [STAGES-1:0][ACC_WIDTH-1:0] prod_pipe_d, prod_pipe_q;
      mac_sb_t [STAGES-1:0]                sb_pipe_d, sb_pipe_q;

      // Shift product, valid and side-band one stage per enabled edge.
      always_comb begin
         vld_pipe_d[0]  = in_vld_q;
         prod_pipe_d[0] = prod0;
         sb_pipe_d[0]   = in_sb_q;
         for (int i = 1; i < STAGES; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            prod_pipe_d[i] = prod_pipe_q[i-1];
            sb_pipe_d[i]   = sb_pipe_q[i-1];
         end
      end

      // Product pipeline registers.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_pipe_q  <= '0;
            prod_pipe_q <= '0;
            sb_pipe_q   <= '0;
         end else if (en) begin
            vld_pipe_q  <= vld_pipe_d;
            prod_pipe_q <= prod_pipe_d;
            sb_pipe_q   <= sb_pipe_d;
         end
      end

      assign prod_valid = vld_pipe_q[STAGES-1];
      assign prod       = prod_pipe_q[STAGES-1];
      assign prod_sb    = sb_pipe_q[STAGES-1];
   end

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply / multiply-accumulate / multiply-subtract with a
// wrapping accumulator and sticky signed-overflow flag.
module mac_pipe
   import mac_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int STAGES    = STAGES_DEF,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_a,
   input  logic                 signed_b,
   input  logic [1:0]           mode,
   input  logic                 clr_acc,
   output logic                 out_valid,
   output logic [ACC_WIDTH-1:0] p,
   output logic                 overflow
);

   logic                 prod_valid;
   logic [ACC_WIDTH-1:0] prod;
   mac_sb_t              prod_sb;

   mac_mult_pipe #(
      .WIDTH     (WIDTH),
      .STAGES    (STAGES),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_mult (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_valid   (in_valid),
      .a          (a),
      .b          (b),
      .signed_a   (signed_a),
      .signed_b   (signed_b),
      .mode       (mode),
      .clr_acc    (clr_acc),
      .prod_valid (prod_valid),
      .prod       (prod),
      .prod_sb    (prod_sb)
   );

   localparam int MSB = ACC_WIDTH - 1;

   logic [ACC_WIDTH-1:0] acc_d, acc_q;
   logic                 ovf_d, ovf_q;
   logic                 out_valid_d, out_valid_q;
   logic [ACC_WIDTH-1:0] base, sum, diff;

   // Accumulator update: clr_acc swaps the running value for zero so MAC
   // loads +prod and MSUB loads -prod; overflow is sticky until a clear or MUL.
   always_comb begin
      base        = prod_sb.clr ? '0 : acc_q;
      sum         = base + prod;
      diff        = base - prod;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      out_valid_d = prod_valid;
      if (prod_valid) begin
         case (prod_sb.mode)
            MODE_MAC: begin
               acc_d = sum;
               ovf_d = (ovf_q & ~prod_sb.clr) | add_ovf(base[MSB], prod[MSB], sum[MSB]);
            end
            MODE_MSUB: begin
               acc_d = diff;
               ovf_d = (ovf_q & ~prod_sb.clr) | add_ovf(base[MSB], ~prod[MSB], diff[MSB]);
            end
            default: begin
               // MUL and the reserved encoding both load the product.
               acc_d = prod;
               ovf_d = 1'b0;
            end
         endcase
      end
   end

   // Accumulator, overflow and output-valid registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (en) begin
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign p         = acc_q;
   assign overflow  = ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed self-checking bench for mac_pipe: default configuration plus a
// narrow WIDTH=4/ACC_WIDTH=8/STAGES=2 instance for overflow behaviour.
module tb_mac_pipe;
   import mac_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;

   // default instance
   logic        iv = 1'b0;
   logic [17:0] a = '0, b = '0;
   logic        sa = 1'b0, sb = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        clr = 1'b0;
   logic        ov;
   logic [47:0] p;
   logic        ovf;

   // narrow instance
   logic        iv2 = 1'b0;
   logic [3:0]  a2 = '0, b2 = '0;
   logic        sa2 = 1'b0, sb2 = 1'b0;
   logic [1:0]  mode2 = 2'd0;
   logic        clr2 = 1'b0;
   logic        ov2;
   logic [7:0]  p2;
   logic        ovf2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_pipe u_dut (
      .clk (clk), .rst (rst), .en (en), .in_valid (iv), .a (a), .b (b),
      .signed_a (sa), .signed_b (sb), .mode (mode), .clr_acc (clr),
      .out_valid (ov), .p (p), .overflow (ovf)
   );

   mac_pipe #(.WIDTH (4), .STAGES (2), .ACC_WIDTH (8)) u_small (
      .clk (clk), .rst (rst), .en (en), .in_valid (iv2), .a (a2), .b (b2),
      .signed_a (sa2), .signed_b (sb2), .mode (mode2), .clr_acc (clr2),
      .out_valid (ov2), .p (p2), .overflow (ovf2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [17:0] ia, input logic [17:0] ib,
                      input logic isa, input logic isb, input logic [1:0] im, input logic ic);
      iv = v; a = ia; b = ib; sa = isa; sb = isb; mode = im; clr = ic;
   endtask

   task automatic drv2(input logic v, input logic [3:0] ia, input logic [3:0] ib,
                       input logic [1:0] im, input logic ic);
      iv2 = v; a2 = ia; b2 = ib; sa2 = 1'b1; sb2 = 1'b1; mode2 = im; clr2 = ic;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      checks++; if (p !== 48'h0 || ov !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL reset_big: p=%h ov=%b ovf=%b want 0/0/0", p, ov, ovf);
      end
      checks++; if (p2 !== 8'h0 || ov2 !== 1'b0 || ovf2 !== 1'b0) begin
         errors++; $display("FAIL reset_small: p=%h ov=%b ovf=%b want 0/0/0", p2, ov2, ovf2);
      end
      rst = 1'b0;
      tick;
   endtask

   // Single sample, checks the pulse position and holding of p afterwards.
   task automatic test_mul(input string nm, input logic [17:0] ia, input logic [17:0] ib,
                           input logic isa, input logic isb, input logic [47:0] exp);
      drv(1'b1, ia, ib, isa, isb, MODE_MUL, 1'b0);
      tick;
      drv(1'b0, '0, '0, 1'b0, 1'b0, MODE_MUL, 1'b0);
      checks++; if (ov !== 1'b0) begin
         errors++; $display("FAIL %s_lat1: out_valid=%b want 0", nm, ov);
      end
      tick;
      checks++; if (ov !== 1'b0) begin
         errors++; $display("FAIL %s_lat2: out_valid=%b want 0", nm, ov);
      end
      tick;
      checks++; if (ov !== 1'b1 || p !== exp) begin
         errors++; $display("FAIL %s: out_valid=%b p=%h want 1 %h", nm, ov, p, exp);
      end
      tick;
      checks++; if (ov !== 1'b0 || p !== exp) begin
         errors++; $display("FAIL %s_hold: out_valid=%b p=%h want 0 %h", nm, ov, p, exp);
      end
   endtask

   task automatic test_back_to_back;
      logic [17:0] va [3] = '{18'd2, 18'd4, 18'd1};
      logic [17:0] vb [3] = '{18'd3, 18'd5, 18'd1};
      logic [47:0] ex [3] = '{48'd6, 48'd26, 48'd27};
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drv(1'b1, va[i], vb[i], 1'b0, 1'b0, MODE_MAC, i == 0);
         else       drv(1'b0, '0, '0, 1'b0, 1'b0, MODE_MUL, 1'b0);
         tick;
         if (i >= 2) begin
            checks++; if (ov !== 1'b1 || p !== ex[i-2]) begin
               errors++; $display("FAIL b2b_%0d: out_valid=%b p=%0d want 1 %0d", i-2, ov, p, ex[i-2]);
            end
         end
      end
      tick;
      checks++; if (ov !== 1'b0 || p !== 48'd27) begin
         errors++; $display("FAIL b2b_end: out_valid=%b p=%0d want 0 27", ov, p);
      end
   endtask

   task automatic test_msub_chain;
      logic [17:0] va [5] = '{18'd2, 18'd1, 18'd5, 18'd7, 18'd1};
      logic [17:0] vb [5] = '{18'd3, 18'd4, 18'd5, 18'd1, 18'd1};
      logic [1:0]  vm [5] = '{MODE_MAC, MODE_MSUB, MODE_MSUB, 2'd3, MODE_MAC};
      logic        vc [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [47:0] ex [5] = '{48'd6, 48'd2, 48'hFFFF_FFFF_FFE7, 48'd7, 48'd8};
      for (int i = 0; i < 7; i++) begin
         if (i < 5) drv(1'b1, va[i], vb[i], 1'b0, 1'b0, vm[i], vc[i]);
         else       drv(1'b0, '0, '0, 1'b0, 1'b0, MODE_MUL, 1'b0);
         tick;
         if (i >= 2) begin
            checks++; if (ov !== 1'b1 || p !== ex[i-2] || ovf !== 1'b0) begin
               errors++; $display("FAIL msub_%0d: out_valid=%b p=%h ovf=%b want 1 %h 0",
                                  i-2, ov, p, ovf, ex[i-2]);
            end
         end
      end
      tick;
   endtask

   task automatic test_stall;
      drv(1'b1, 18'd2, 18'd3, 1'b0, 1'b0, MODE_MAC, 1'b1); tick;
      drv(1'b1, 18'd4, 18'd5, 1'b0, 1'b0, MODE_MAC, 1'b0); tick;
      drv(1'b1, 18'd1, 18'd1, 1'b0, 1'b0, MODE_MAC, 1'b0); tick;
      checks++; if (ov !== 1'b1 || p !== 48'd6) begin
         errors++; $display("FAIL stall_first: out_valid=%b p=%0d want 1 6", ov, p);
      end
      en = 1'b0;
      drv(1'b1, 18'd9, 18'd9, 1'b0, 1'b0, MODE_MUL, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++; if (ov !== 1'b1 || p !== 48'd6) begin
            errors++; $display("FAIL stall_hold_%0d: out_valid=%b p=%0d want 1 6", i, ov, p);
         end
      end
      en = 1'b1;
      drv(1'b0, '0, '0, 1'b0, 1'b0, MODE_MUL, 1'b0);
      tick;
      checks++; if (ov !== 1'b1 || p !== 48'd26) begin
         errors++; $display("FAIL stall_second: out_valid=%b p=%0d want 1 26", ov, p);
      end
      tick;
      checks++; if (ov !== 1'b1 || p !== 48'd27) begin
         errors++; $display("FAIL stall_third: out_valid=%b p=%0d want 1 27", ov, p);
      end
      tick;
      checks++; if (ov !== 1'b0 || p !== 48'd27) begin
         errors++; $display("FAIL stall_end: out_valid=%b p=%0d want 0 27", ov, p);
      end
   endtask

   task automatic test_overflow;
      logic [3:0] va [4] = '{4'h8, 4'h8, 4'h0, 4'h1};
      logic [3:0] vb [4] = '{4'h8, 4'h8, 4'h0, 4'h1};
      logic       vc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] ex [4] = '{8'h40, 8'h80, 8'h80, 8'h01};
      logic       eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         if (i < 4) drv2(1'b1, va[i], vb[i], MODE_MAC, vc[i]);
         else       drv2(1'b0, '0, '0, MODE_MUL, 1'b0);
         tick;
         if (i < 3) begin
            checks++; if (ov2 !== 1'b0) begin
               errors++; $display("FAIL ovf_lat_%0d: out_valid=%b want 0", i, ov2);
            end
         end else begin
            checks++; if (ov2 !== 1'b1 || p2 !== ex[i-3] || ovf2 !== eo[i-3]) begin
               errors++; $display("FAIL ovf_%0d: out_valid=%b p=%h ovf=%b want 1 %h %b",
                                  i-3, ov2, p2, ovf2, ex[i-3], eo[i-3]);
            end
         end
      end
      tick;
   endtask

   task automatic test_reset_inflight;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 2) drv2(1'b1, 4'h8, 4'h8, MODE_MAC, i == 1);
         else        drv2(1'b0, '0, '0, MODE_MUL, 1'b0);
         if (i >= 3) drv(1'b1, 18'd3 + 18'(i), 18'd4, 1'b0, 1'b0, MODE_MUL, 1'b0);
         else        drv(1'b0, '0, '0, 1'b0, 1'b0, MODE_MUL, 1'b0);
         tick;
      end
      drv(1'b0, '0, '0, 1'b0, 1'b0, MODE_MUL, 1'b0);
      drv2(1'b0, '0, '0, MODE_MUL, 1'b0);
      checks++; if (ov !== 1'b1 || p !== 48'd24 || ovf2 !== 1'b1) begin
         errors++; $display("FAIL rst_pre: out_valid=%b p=%0d ovf_small=%b want 1 24 1", ov, p, ovf2);
      end
      #1 rst = 1'b1;
      #1;
      checks++; if (ov !== 1'b0 || p !== 48'h0 || ovf !== 1'b0) begin
         errors++; $display("FAIL rst_async_big: out_valid=%b p=%h ovf=%b want 0 0 0", ov, p, ovf);
      end
      checks++; if (ov2 !== 1'b0 || p2 !== 8'h0 || ovf2 !== 1'b0) begin
         errors++; $display("FAIL rst_async_small: out_valid=%b p=%h ovf=%b want 0 0 0", ov2, p2, ovf2);
      end
      tick;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         checks++; if (ov !== 1'b0 || ov2 !== 1'b0) begin
            errors++; $display("FAIL rst_flush_%0d: out_valid=%b/%b want 0/0", i, ov, ov2);
         end
      end
      drv(1'b1, 18'd3, 18'd3, 1'b0, 1'b0, MODE_MUL, 1'b0); tick;
      drv(1'b0, '0, '0, 1'b0, 1'b0, MODE_MUL, 1'b0); tick; tick;
      checks++; if (ov !== 1'b1 || p !== 48'd9) begin
         errors++; $display("FAIL rst_first_after: out_valid=%b p=%0d want 1 9", ov, p);
      end
   endtask

   initial begin
      test_reset;
      test_mul("mul_signed", 18'h3FFFD, 18'd5, 1'b1, 1'b1, 48'hFFFF_FFFF_FFF1);
      test_mul("mul_unsigned", 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 48'h000F_FFF8_0001);
      test_mul("mul_mixed", 18'h3FFFD, 18'h3FFFF, 1'b1, 1'b0, 48'hFFFF_FFF4_0003);
      test_back_to_back;
      test_msub_chain;
      test_stall;
      test_overflow;
      test_reset_inflight;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
